// File: rtl/mul6_seq_ctrl_pkg.sv
// ============================================================================
// Module : mul6_seq_ctrl_pkg
// Desc   : Shared constants and helpers for the 6x6 sequential multiplier.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul6_seq_ctrl_pkg;

  localparam int OPW = 6;
  localparam int DGW = 3;
  localparam int PW  = 12;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Partial-product shift per step, indexed by step (entry 0 is the LSB slice).
  localparam logic [3:0][2:0] SHIFT_TABLE = {3'd6, 3'd3, 3'd3, 3'd0};

  function automatic logic [2:0] step_shift(input logic [1:0] step);
    return SHIFT_TABLE[step];
  endfunction

  function automatic logic [DGW-1:0] digit_sel(input logic [OPW-1:0] v, input logic hi);
    return hi ? v[5:3] : v[2:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul6_seq_ctrl_three_bit_multiplier.sv
// ============================================================================
// Module : three_bit_multiplier
// Desc   : Combinational 3x3 unsigned multiplier core (shift-and-add).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module three_bit_multiplier (
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [5:0] pp
);

  logic [5:0] w_row0;
  logic [5:0] w_row1;
  logic [5:0] w_row2;

  assign w_row0 = {3'b000, x}       & {6{y[0]}};
  assign w_row1 = {2'b00, x, 1'b0}  & {6{y[1]}};
  assign w_row2 = {1'b0, x, 2'b00}  & {6{y[2]}};

  assign pp = w_row0 + w_row1 + w_row2;

endmodule

`default_nettype wire

// File: rtl/mul6_seq_ctrl.sv
// ============================================================================
// Module : mul6_seq_ctrl
// Desc   : 6x6 unsigned multiplier time-sharing one 3x3 core over four steps.
//          Optional macro MUL6_SEQ_ZERO_SKIP_EN bypasses CALC for zero operands.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul6_seq_ctrl
  import mul6_seq_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  p,
  output logic           busy
);

  logic [1:0]     r_state;
  logic [1:0]     r_step;
  logic [OPW-1:0] r_a;
  logic [OPW-1:0] r_b;
  logic [PW-1:0]  r_acc;
  logic [PW-1:0]  r_p;
  logic           r_out_valid;

  logic [DGW-1:0] w_dig_a;
  logic [DGW-1:0] w_dig_b;
  logic [5:0]     w_pp;
  logic [2:0]     w_sh;
  logic [PW-1:0]  w_pp_shifted;
  logic [PW-1:0]  w_acc_next;
  logic           w_zero_op;

  // step[0] picks the high digit of a, step[1] the high digit of b.
  assign w_dig_a = digit_sel(r_a, r_step[0]);
  assign w_dig_b = digit_sel(r_b, r_step[1]);

  three_bit_multiplier u_core (
    .x  (w_dig_a),
    .y  (w_dig_b),
    .pp (w_pp)
  );

  assign w_sh         = step_shift(r_step);
  assign w_pp_shifted = {6'd0, w_pp} << w_sh;
  assign w_acc_next   = r_acc + w_pp_shifted;

`ifdef MUL6_SEQ_ZERO_SKIP_EN
  assign w_zero_op = (a == '0) || (b == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_step      <= 2'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_step <= 2'd0;
            if (w_zero_op) begin
              r_state     <= DONE;
              r_p         <= '0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc  <= w_acc_next;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_state     <= DONE;
            r_p         <= w_acc_next;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == CALC) || (r_state == DONE);
  assign out_valid = r_out_valid;
  assign p         = r_p;

endmodule

`default_nettype wire
